// File: rtl/serial_mod_n_checker.sv
// Serial divisibility checker: folds a bit stream into a running remainder mod DIVISOR
// and reports the final remainder, divisibility and length of each completed frame.
module serial_mod_n_checker #(
  parameter int DIVISOR   = 3,
  parameter bit MSB_FIRST = 1'b1,
  parameter int CNT_W     = 16,
  localparam int REM_W    = ($clog2(DIVISOR) > 1) ? $clog2(DIVISOR) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_valid,
  input  logic             bit_in,
  input  logic             frame_start,
  input  logic             frame_end,
  output logic [REM_W-1:0] remainder,
  output logic             divisible,
  output logic             result_valid,
  output logic             result_divisible,
  output logic [REM_W-1:0] result_remainder,
  output logic [CNT_W-1:0] frame_len
);

  localparam logic [REM_W:0]   DIV_EXT = (REM_W + 1)'(DIVISOR);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [REM_W-1:0] P_ONE   = REM_W'(1);

  logic [REM_W-1:0] rem_q, rem_d, p_q, p_d, res_rem_q, res_rem_d;
  logic             div_q, div_d, rv_q, rv_d, res_div_q, res_div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, len_q, len_d;

  logic [REM_W-1:0] r_eff, p_eff, rem_upd, p_upd;
  logic [REM_W:0]   t_rem, t_p;
  logic [CNT_W-1:0] cnt_upd;

  // Both operands stay below DIVISOR, so one conditional subtract fully reduces each sum.
  always_comb begin
    r_eff = frame_start ? '0 : rem_q;
    p_eff = frame_start ? P_ONE : p_q;

    if (MSB_FIRST) begin
      t_rem = {r_eff, 1'b0} + {{REM_W{1'b0}}, bit_in};
    end else begin
      t_rem = {1'b0, r_eff} + (bit_in ? {1'b0, p_eff} : '0);
    end
    rem_upd = (t_rem >= DIV_EXT) ? REM_W'(t_rem - DIV_EXT) : t_rem[REM_W-1:0];

    t_p   = {p_eff, 1'b0};
    p_upd = (t_p >= DIV_EXT) ? REM_W'(t_p - DIV_EXT) : t_p[REM_W-1:0];

    if (frame_start) begin
      cnt_upd = CNT_W'(1);
    end else if (cnt_q == CNT_MAX) begin
      cnt_upd = cnt_q;
    end else begin
      cnt_upd = cnt_q + CNT_W'(1);
    end
  end

  // A completed frame publishes its result and rewinds the running state to start values.
  always_comb begin
    rem_d     = rem_q;
    p_d       = p_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    rv_d      = 1'b0;
    res_rem_d = res_rem_q;
    res_div_d = res_div_q;
    len_d     = len_q;

    if (bit_valid) begin
      if (frame_end) begin
        rem_d     = '0;
        p_d       = P_ONE;
        cnt_d     = '0;
        div_d     = 1'b1;
        rv_d      = 1'b1;
        res_rem_d = rem_upd;
        res_div_d = (rem_upd == '0);
        len_d     = cnt_upd;
      end else begin
        rem_d = rem_upd;
        p_d   = p_upd;
        cnt_d = cnt_upd;
        div_d = (rem_upd == '0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q     <= '0;
      p_q       <= P_ONE;
      cnt_q     <= '0;
      div_q     <= 1'b1;
      rv_q      <= 1'b0;
      res_rem_q <= '0;
      res_div_q <= 1'b0;
      len_q     <= '0;
    end else begin
      rem_q     <= rem_d;
      p_q       <= p_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      rv_q      <= rv_d;
      res_rem_q <= res_rem_d;
      res_div_q <= res_div_d;
      len_q     <= len_d;
    end
  end

  assign remainder        = rem_q;
  assign divisible        = div_q;
  assign result_valid     = rv_q;
  assign result_remainder = res_rem_q;
  assign result_divisible = res_div_q;
  assign frame_len        = len_q;

endmodule

// File: tb/tb_serial_mod_n_checker.sv
// Directed bench: several checker configurations share one input stream; each scenario
// resets everything and then checks only the instance it targets.
module tb_serial_mod_n_checker;

  logic clk;
  logic rst;
  logic bit_valid;
  logic bit_in;
  logic frame_start;
  logic frame_end;

  int checks = 0;
  int errors = 0;

  logic [1:0]  u3_rem;  logic u3_div;  logic u3_rv;  logic u3_rdiv;  logic [1:0] u3_rrem;  logic [15:0] u3_len;
  logic [2:0]  u5_rem;  logic u5_div;  logic u5_rv;  logic u5_rdiv;  logic [2:0] u5_rrem;  logic [15:0] u5_len;
  logic [2:0]  u7_rem;  logic u7_div;  logic u7_rv;  logic u7_rdiv;  logic [2:0] u7_rrem;  logic [15:0] u7_len;
  logic        u2_rem;  logic u2_div;  logic u2_rv;  logic u2_rdiv;  logic       u2_rrem;  logic [15:0] u2_len;
  logic [1:0]  us_rem;  logic us_div;  logic us_rv;  logic us_rdiv;  logic [1:0] us_rrem;  logic [1:0]  us_len;

  serial_mod_n_checker #(.DIVISOR(3), .MSB_FIRST(1'b1), .CNT_W(16)) u3 (
    .clk(clk), .rst(rst), .bit_valid(bit_valid), .bit_in(bit_in),
    .frame_start(frame_start), .frame_end(frame_end),
    .remainder(u3_rem), .divisible(u3_div), .result_valid(u3_rv),
    .result_divisible(u3_rdiv), .result_remainder(u3_rrem), .frame_len(u3_len));

  serial_mod_n_checker #(.DIVISOR(5), .MSB_FIRST(1'b1), .CNT_W(16)) u5 (
    .clk(clk), .rst(rst), .bit_valid(bit_valid), .bit_in(bit_in),
    .frame_start(frame_start), .frame_end(frame_end),
    .remainder(u5_rem), .divisible(u5_div), .result_valid(u5_rv),
    .result_divisible(u5_rdiv), .result_remainder(u5_rrem), .frame_len(u5_len));

  serial_mod_n_checker #(.DIVISOR(7), .MSB_FIRST(1'b0), .CNT_W(16)) u7 (
    .clk(clk), .rst(rst), .bit_valid(bit_valid), .bit_in(bit_in),
    .frame_start(frame_start), .frame_end(frame_end),
    .remainder(u7_rem), .divisible(u7_div), .result_valid(u7_rv),
    .result_divisible(u7_rdiv), .result_remainder(u7_rrem), .frame_len(u7_len));

  serial_mod_n_checker #(.DIVISOR(2), .MSB_FIRST(1'b1), .CNT_W(16)) u2 (
    .clk(clk), .rst(rst), .bit_valid(bit_valid), .bit_in(bit_in),
    .frame_start(frame_start), .frame_end(frame_end),
    .remainder(u2_rem), .divisible(u2_div), .result_valid(u2_rv),
    .result_divisible(u2_rdiv), .result_remainder(u2_rrem), .frame_len(u2_len));

  serial_mod_n_checker #(.DIVISOR(3), .MSB_FIRST(1'b1), .CNT_W(2)) us (
    .clk(clk), .rst(rst), .bit_valid(bit_valid), .bit_in(bit_in),
    .frame_start(frame_start), .frame_end(frame_end),
    .remainder(us_rem), .divisible(us_div), .result_valid(us_rv),
    .result_divisible(us_rdiv), .result_remainder(us_rrem), .frame_len(us_len));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after a rising edge; outputs are sampled 1 unit after the next.
  task automatic applyStimulus(input logic v, input logic b, input logic s, input logic e);
    bit_valid   = v;
    bit_in      = b;
    frame_start = s;
    frame_end   = e;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic resetDut();
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bit_valid = 1'b0; bit_in = 1'b0; frame_start = 1'b0; frame_end = 1'b0;
    @(posedge clk);
    #1;

    // Reset state
    resetDut();
    checkOutput("rst_rem",   32'(u3_rem),  32'd0);
    checkOutput("rst_div",   32'(u3_div),  32'd1);
    checkOutput("rst_rv",    32'(u3_rv),   32'd0);
    checkOutput("rst_rdiv",  32'(u3_rdiv), 32'd0);
    checkOutput("rst_rrem",  32'(u3_rrem), 32'd0);
    checkOutput("rst_len",   32'(u3_len),  32'd0);

    // DIVISOR=3 MSB-first: 110 = 6
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("d3_rem1", 32'(u3_rem), 32'd1);
    checkOutput("d3_div1", 32'(u3_div), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("d3_rem2", 32'(u3_rem), 32'd0);
    checkOutput("d3_rv_pre", 32'(u3_rv), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("d3_rv",   32'(u3_rv),   32'd1);
    checkOutput("d3_rrem", 32'(u3_rrem), 32'd0);
    checkOutput("d3_rdiv", 32'(u3_rdiv), 32'd1);
    checkOutput("d3_len",  32'(u3_len),  32'd3);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("d3_rv_once", 32'(u3_rv),  32'd0);
    checkOutput("d3_len_hold", 32'(u3_len), 32'd3);

    // DIVISOR=5 MSB-first: 111 = 7
    resetDut();
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("d5_rem1", 32'(u5_rem), 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("d5_rem2", 32'(u5_rem), 32'd3);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("d5_rv",   32'(u5_rv),   32'd1);
    checkOutput("d5_rrem", 32'(u5_rrem), 32'd2);
    checkOutput("d5_rdiv", 32'(u5_rdiv), 32'd0);
    checkOutput("d5_len",  32'(u5_len),  32'd3);

    // DIVISOR=7 LSB-first: bits 0,1,1,1 = 14
    resetDut();
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("d7_rem1", 32'(u7_rem), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("d7_rem2", 32'(u7_rem), 32'd2);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("d7_rem3", 32'(u7_rem), 32'd6);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("d7_rv",   32'(u7_rv),   32'd1);
    checkOutput("d7_rrem", 32'(u7_rrem), 32'd0);
    checkOutput("d7_rdiv", 32'(u7_rdiv), 32'd1);
    checkOutput("d7_len",  32'(u7_len),  32'd4);

    // DIVISOR=3 with bit_valid gaps; control inputs during gaps must be ignored
    resetDut();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("gap_rem1", 32'(u3_rem), 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput("gap_hold1", 32'(u3_rem), 32'd1);
    checkOutput("gap_rv1",   32'(u3_rv),  32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("gap_hold2", 32'(u3_rem), 32'd1);
    checkOutput("gap_rv2",   32'(u3_rv),  32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("gap_rem2", 32'(u3_rem), 32'd0);
    checkOutput("gap_div2", 32'(u3_div), 32'd1);
    checkOutput("gap_rv3",  32'(u3_rv),  32'd0);

    // DIVISOR=2 one-bit frames, back to back
    resetDut();
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    checkOutput("one_rv1",   32'(u2_rv),   32'd1);
    checkOutput("one_rrem1", 32'(u2_rrem), 32'd1);
    checkOutput("one_rdiv1", 32'(u2_rdiv), 32'd0);
    checkOutput("one_len1",  32'(u2_len),  32'd1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    checkOutput("one_rv2",   32'(u2_rv),   32'd1);
    checkOutput("one_rrem2", 32'(u2_rrem), 32'd0);
    checkOutput("one_rdiv2", 32'(u2_rdiv), 32'd1);

    // Mid-frame reset (with bit_valid high), then a frame computed from zero
    resetDut();
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("mrst_pre", 32'(u3_rem), 32'd2);
    rst = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    rst = 1'b0;
    checkOutput("mrst_rem", 32'(u3_rem), 32'd0);
    checkOutput("mrst_div", 32'(u3_div), 32'd1);
    checkOutput("mrst_rv",  32'(u3_rv),  32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("mrst_rv2",  32'(u3_rv),   32'd1);
    checkOutput("mrst_rrem", 32'(u3_rrem), 32'd1);
    checkOutput("mrst_len",  32'(u3_len),  32'd3);

    // frame_start mid-frame abandons the open frame: result is only for "10"
    resetDut();
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("abn_rv0",  32'(u3_rv),  32'd0);
    checkOutput("abn_rem",  32'(u3_rem), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("abn_rv",   32'(u3_rv),   32'd1);
    checkOutput("abn_rrem", 32'(u3_rrem), 32'd2);
    checkOutput("abn_len",  32'(u3_len),  32'd2);

    // 10110 = 22: length 5, which saturates at 3 in a 2-bit counter
    resetDut();
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("sat_rrem",  32'(u3_rrem), 32'd1);
    checkOutput("sat_len16", 32'(u3_len),  32'd5);
    checkOutput("sat_len2",  32'(us_len),  32'd3);
    checkOutput("sat_rv2",   32'(us_rv),   32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_mod_n_checker.md
SERIAL_MOD_N_CHECKER -- requirements
Module: serial_mod_n_checker

Interface
REQ-001 The block SHALL have parameter DIVISOR, default 3, the modulus: an integer in the range 2..255.
REQ-002 The block SHALL have parameter MSB_FIRST, default 1: 1 means the stream arrives MSB first, 0 means LSB first.
REQ-003 The block SHALL have parameter CNT_W, default 16, the width of the frame bit counter.
REQ-004 The block SHALL derive local parameter REM_W = max(1, clog2(DIVISOR)).
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on posedge clk.
REQ-006 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port bit_valid, input, 1 bit: bit_in, frame_start and frame_end are qualified this cycle.
REQ-008 The block SHALL have port bit_in, input, 1 bit: the serial data bit.
REQ-009 The block SHALL have port frame_start, input, 1 bit: the current valid bit is the first bit of a new number.
REQ-010 The block SHALL have port frame_end, input, 1 bit: the current valid bit is the last bit of the number.
REQ-011 The block SHALL have port remainder, output, REM_W bits: the running remainder of the current frame, registered.
REQ-012 The block SHALL have port divisible, output, 1 bit: registered, equal to (remainder == 0).
REQ-013 The block SHALL have port result_valid, output, 1 bit: a one-cycle pulse when a frame completes.
REQ-014 The block SHALL have port result_divisible, output, 1 bit: the final divisibility of the last completed frame, held between frames.
REQ-015 The block SHALL have port result_remainder, output, REM_W bits: the final remainder of the last completed frame, held between frames.
REQ-016 The block SHALL have port frame_len, output, CNT_W bits: the bit count of the last completed frame, saturating.

Function
REQ-017 When bit_valid=0, all state SHALL hold, frame_start and frame_end SHALL be ignored, and result_valid SHALL be 0.
REQ-018 Let r be the effective prior remainder: 0 if frame_start=1, else the current remainder.
REQ-019 In MSB-first mode, the next remainder SHALL be t = 2r + bit_in, reduced by a single conditional subtract of DIVISOR when t >= DIVISOR; no divider or multiplier SHALL be used.
REQ-020 In LSB-first mode, the block SHALL keep a weight register p = 2^k mod DIVISOR, where k is the bit index within the frame.
REQ-021 In LSB-first mode, the effective weight p SHALL be 1 if frame_start=1, else the current p.
REQ-022 In LSB-first mode, the next remainder SHALL be (r + bit_in*p) mod DIVISOR and the next p SHALL be (2p) mod DIVISOR, each computed by a single conditional subtract.
REQ-023 The running bit counter SHALL be set to 1 on frame_start and otherwise increment per valid bit, saturating at 2^CNT_W-1.
REQ-024 Valid bits arriving without any prior frame_start SHALL accumulate onto the current state, which is 0 after reset.
REQ-025 A valid bit with frame_end=1 SHALL assert result_valid one cycle later (latency 1).
REQ-026 On that cycle, result_remainder, result_divisible and frame_len SHALL equal the updated remainder, (updated remainder == 0) and the updated count.
REQ-027 After a completed frame, the running remainder, p and counter SHALL reset to their start values, so the next bit begins a new frame even without frame_start.
REQ-028 frame_start=1 together with frame_end=1 on one valid bit SHALL be treated as a one-bit frame: result_remainder = bit_in mod DIVISOR and frame_len = 1.
REQ-029 frame_start asserted mid-frame SHALL silently abandon the open frame; no result SHALL be produced for it.
REQ-030 Back-to-back frame_end on consecutive valid cycles SHALL produce consecutive result_valid pulses, with no loss of results.

Reset
REQ-031 While rst=1, the block SHALL set remainder=0, divisible=1, p=1, the counter=0, result_valid=0, result_divisible=0, result_remainder=0 and frame_len=0.
REQ-032 rst SHALL take priority over bit_valid.
REQ-033 Reset mid-frame SHALL discard the open frame with no result_valid produced.

Verification
REQ-034 The bench SHALL cover: DIVISOR=3, MSB-first, bits 1,1,0 with start on the first bit and end on the last -> result_valid once, result_remainder=0, result_divisible=1, frame_len=3.
REQ-035 The bench SHALL cover: DIVISOR=5, MSB-first, stream 1,1,1 (7) -> remainder sequence 1,3,2; result_remainder=2, result_divisible=0.
REQ-036 The bench SHALL cover: DIVISOR=7, LSB-first, bits 0,1,1,1 (14) -> result_remainder=0, result_divisible=1, frame_len=4.
REQ-037 The bench SHALL cover: DIVISOR=3, bit_valid toggling 1,0,0,1 with bits 1,x,x,1 -> remainder 1 held during the gaps, then 0; no result_valid without frame_end.
REQ-038 The bench SHALL cover: a single cycle with start=end=1 and bit_in=1, DIVISOR=2 -> result_remainder=1 and frame_len=1; then a bit_in=0 one-bit frame -> result_divisible=1 on the next pulse.
REQ-039 The bench SHALL cover: rst asserted after 2 bits of an open frame -> remainder=0, divisible=1, no result_valid; the following frame is computed from 0.
